// File: rtl/irq_encoder_pkg.sv
// Shared constants and FSM state type for the edge-captured interrupt encoder.
package irq_encoder_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned VEC_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/irq_encoder_prio_enc8.sv
// 8-to-3 priority encoder: highest set index wins, plus an any-set flag.
module prio_enc8
  import irq_encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [VEC_W-1:0]   idx,
  output logic               any
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        idx = VEC_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_encoder.sv
// Edge-captured 8-line interrupt encoder: pending latch, priority pick and
// a present/acknowledge/release handshake with a one-cycle release gap.
module irq_encoder
  import irq_encoder_pkg::*;
(
  input  logic               CLK,
  input  logic               N_RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               N_EI,
  input  logic               ACK,
  output logic [VEC_W-1:0]   VEC,
  output logic               VALID,
  output logic               N_GS,
  output logic               N_EO
);

  state_t             state;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] edges;
  logic [NUM_REQ-1:0] clr_mask;
  logic [VEC_W-1:0]   win;
  logic               any;

  prio_enc8 u_prio (
    .req (pending),
    .idx (win),
    .any (any)
  );

  assign edges = REQ & ~req_q;

  always_comb begin
    clr_mask = '0;
    if (state == ST_PRESENT && ACK)
      clr_mask[VEC] = 1'b1;
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      pending <= '0;
      VEC     <= '0;
      VALID   <= 1'b0;
    end else begin
      req_q   <= REQ;
      // Edges are OR'd after the clear so a same-cycle re-request survives.
      pending <= (pending & ~clr_mask) | edges;
      case (state)
        ST_IDLE: begin
          if (any && !N_EI) begin
            VEC   <= win;
            VALID <= 1'b1;
            state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ACK) begin
            VALID <= 1'b0;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign N_GS = !VALID;
  assign N_EO = N_EI || (state != ST_IDLE) || (|pending);

  a_vec_stable: assert property (@(posedge CLK) disable iff (!N_RST)
    (VALID && $past(VALID)) |-> $stable(VEC));

  a_load_pending: assert property (@(posedge CLK) disable iff (!N_RST)
    (state == ST_IDLE && any && !N_EI) |-> pending[win]);

  a_valid_pending: assert property (@(posedge CLK) disable iff (!N_RST)
    VALID |-> pending[VEC]);

  a_gs: assert property (@(posedge CLK) disable iff (!N_RST)
    N_GS == !VALID);

endmodule

// File: tb/tb_irq_encoder.sv
// Directed and random checks of irq_encoder against a cycle-level reference model.
module tb_irq_encoder;

  logic       CLK = 1'b0;
  logic       N_RST;
  logic [7:0] REQ;
  logic       N_EI;
  logic       ACK;
  logic [2:0] VEC;
  logic       VALID;
  logic       N_GS;
  logic       N_EO;

  int n_checks = 0;
  int n_fail   = 0;

  irq_encoder dut (
    .CLK   (CLK),
    .N_RST (N_RST),
    .REQ   (REQ),
    .N_EI  (N_EI),
    .ACK   (ACK),
    .VEC   (VEC),
    .VALID (VALID),
    .N_GS  (N_GS),
    .N_EO  (N_EO)
  );

  always #5 CLK = ~CLK;

  // Reference model: presentation flag, release-gap flag, pending bits.
  bit       m_valid;
  bit       m_gap;
  int       m_vec;
  bit [7:0] m_pend;
  bit [7:0] m_prev;

  function automatic int highest(input bit [7:0] v);
    for (int i = 7; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_gap = 0; m_vec = 0; m_pend = '0; m_prev = '0;
  endtask

  task automatic model_step();
    bit [7:0] old;
    bit [7:0] newly;
    old   = m_pend;
    newly = REQ & ~m_prev;
    m_prev = REQ;
    m_pend = old;
    if (m_valid) begin
      if (ACK) begin
        m_pend[m_vec] = 1'b0;
        m_valid = 0;
        m_gap   = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (old != 0 && !N_EI) begin
      m_vec   = highest(old);
      m_valid = 1;
    end
    m_pend = m_pend | newly;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit idle;
    idle = !m_valid && !m_gap;
    check("valid", 8'(VALID), 8'(m_valid));
    check("n_gs", 8'(N_GS), 8'(!m_valid));
    check("n_eo", 8'(N_EO), 8'(!(!N_EI && idle && m_pend == 0)));
    check("pending", dut.pending, m_pend);
    if (m_valid) check("vec", 8'(VEC), 8'(m_vec));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ack_and_settle();
    ACK = 1'b1; tick();
    ACK = 1'b0; REQ = 8'h00; ticks(2);
  endtask

  initial begin
    N_RST = 1'b0; REQ = 8'h00; N_EI = 1'b0; ACK = 1'b0;
    model_reset();
    #12;
    check("rst_valid", 8'(VALID), 8'h0);
    check("rst_vec", 8'(VEC), 8'h0);
    check("rst_n_gs", 8'(N_GS), 8'h1);
    check("rst_n_eo", 8'(N_EO), 8'(N_EI));
    @(negedge CLK);
    N_RST = 1'b1;

    // Single low-priority edge: two-edge latency, then N_EO low in idle.
    REQ = 8'h01; ticks(2);
    check("s1_valid", 8'(VALID), 8'h1);
    check("s1_vec", 8'(VEC), 8'h0);
    ACK = 1'b1; tick();
    check("s1_ack_valid", 8'(VALID), 8'h0);
    ACK = 1'b0; REQ = 8'h00; tick();
    check("s1_n_eo", 8'(N_EO), 8'h0);

    // Two edges together: 7 first, then 0.
    REQ = 8'h81; ticks(2);
    check("s2_vec7", 8'(VEC), 8'h7);
    ACK = 1'b1; tick();
    ACK = 1'b0; ticks(2);
    check("s2_valid0", 8'(VALID), 8'h1);
    check("s2_vec0", 8'(VEC), 8'h0);
    ACK = 1'b1; tick();
    check("s2_pend_empty", dut.pending, 8'h00);
    ACK = 1'b0; REQ = 8'h00; ticks(2);

    // Higher edge during presentation does not preempt.
    REQ = 8'h04; ticks(2);
    check("s3_vec2", 8'(VEC), 8'h2);
    REQ = 8'h44; ticks(2);
    check("s3_hold_vec2", 8'(VEC), 8'h2);
    ACK = 1'b1; tick();
    ACK = 1'b0; ticks(2);
    check("s3_vec6", 8'(VEC), 8'h6);
    ack_and_settle();

    // Disabled: edges captured but not presented.
    N_EI = 1'b1; REQ = 8'h18; ticks(3);
    check("s4_no_valid", 8'(VALID), 8'h0);
    check("s4_n_eo", 8'(N_EO), 8'h1);
    N_EI = 1'b0; tick();
    check("s4_vec4", 8'(VEC), 8'h4);
    ACK = 1'b1; tick();
    ACK = 1'b0; ticks(2);
    check("s4_vec3", 8'(VEC), 8'h3);
    ack_and_settle();

    // Acknowledge coincides with a new edge on the presented bit.
    REQ = 8'h02; ticks(2);
    check("s5_vec1", 8'(VEC), 8'h1);
    REQ = 8'h00; tick();
    REQ = 8'h02; ACK = 1'b1; tick();
    check("s5_pend1", 8'(dut.pending[1]), 8'h1);
    ACK = 1'b0; ticks(2);
    check("s5_revalid", 8'(VALID), 8'h1);
    check("s5_vec1_again", 8'(VEC), 8'h1);
    ack_and_settle();

    // Asynchronous reset while presenting; level-high REQ captured after release.
    REQ = 8'h20; ticks(2);
    check("s6_vec5", 8'(VEC), 8'h5);
    REQ = 8'h21; tick();
    #2 N_RST = 1'b0;
    model_reset();
    #1;
    check("s6_rst_valid", 8'(VALID), 8'h0);
    check("s6_rst_pend", dut.pending, 8'h00);
    check("s6_rst_n_gs", 8'(N_GS), 8'h1);
    check("s6_rst_n_eo", 8'(N_EO), 8'(N_EI));
    @(negedge CLK);
    N_RST = 1'b1; ticks(2);
    check("s6_recapture_vec5", 8'(VEC), 8'h5);
    ack_and_settle();
    ACK = 1'b1; tick();
    ACK = 1'b0; ticks(3);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      REQ  = 8'($urandom) & 8'($urandom);
      N_EI = ($urandom_range(0, 4) == 0);
      ACK  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_encoder.md
IRQ_ENCODER -- requirements
Module: irq_encoder

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 N_RST  input  1  reset, asynchronous, active-low.
REQ-003 REQ  input  8  request lines, active-high, edge-captured; REQ[7] is highest priority.
REQ-004 N_EI  input  1  enable input, active-low; high blocks new presentations only.
REQ-005 ACK  input  1  acknowledge from consumer, active-high, sampled only in PRESENT.
REQ-006 VEC  output  3  encoded index of the presented request; held stable while VALID.
REQ-007 VALID  output  1  a vector is being presented.
REQ-008 N_GS  output  1  group select, active-low; equals !VALID.
REQ-009 N_EO  output  1  enable out, active-low; low when N_EI low, state IDLE and no bit pending.

Function
REQ-010 Edge capture: REQ is registered as req_q each cycle; bit i is a rising edge when REQ[i]=1 and req_q[i]=0.
REQ-011 Pending register, 8 bits: an edge on bit i sets pending[i] at that clock edge; level-held requests do not re-set a cleared bit.
REQ-012 Priority: the highest set pending index wins; index 7 beats 0.
REQ-013 FSM states: IDLE, PRESENT, RELEASE.
REQ-014 IDLE -> PRESENT when pending != 0 and N_EI = 0; VEC is loaded with the winning index and VALID = 1 from the next cycle.
REQ-015 IDLE with N_EI = 1: stay in IDLE; edges are still captured into pending.
REQ-016 PRESENT: VEC and VALID hold; a newly arriving higher-priority edge does not change VEC; N_EI rising does not retract VALID.
REQ-017 PRESENT with ACK = 1: clear pending[VEC], go to RELEASE; VALID = 0 from the next cycle.
REQ-018 RELEASE: one cycle with VALID = 0, then unconditional return to IDLE; there are at least 2 idle cycles between successive presentations.
REQ-019 ACK in IDLE or RELEASE is ignored.
REQ-020 Simultaneous set and clear on the same bit: set wins, so the bit stays pending and the new edge is not lost.
REQ-021 Simultaneous set of other bits during the clear: those bits are set and the cleared bit is cleared.
REQ-022 Latency: an edge sampled at edge k in IDLE with N_EI = 0 and pending empty gives VALID = 1 after edge k+1.
REQ-023 N_EO, N_GS: combinational from registered state and N_EI only; no path from REQ or ACK.

Reset
REQ-024 N_RST low asynchronously forces: state IDLE, pending 0, req_q 0, VEC 0, VALID 0, N_GS 1.
REQ-025 N_EO during reset equals N_EI, because pending is empty and the state is IDLE.
REQ-026 A REQ bit already high at reset release is captured as an edge on the first clock.
REQ-027 Reset asserted in PRESENT discards the presentation and all pending bits.

Structure
REQ-028 Shared package holds: NUM_REQ = 8, VEC_W = 3, and the FSM state enum.
REQ-029 One combinational sub-module, prio_enc8 (8 -> 3 plus any-set flag), is instantiated for the winner selection.
REQ-030 The block carries formal assertions: VEC is stable while VALID, VALID implies pending[VEC] was set when loaded, and N_GS == !VALID always.

Verification
REQ-031 Reset mid-PRESENT (VEC = 5) -> VALID 0 and pending 0 immediately, without waiting for a clock.
REQ-032 REQ = 0x01 edge, N_EI = 0 -> VALID after 2 edges, VEC = 0; ACK -> VALID 0, N_EO 0 in IDLE.
REQ-033 REQ = 0x81 on the same edge -> VEC = 7 first; after ACK and RELEASE -> VEC = 0 presented; after second ACK pending = 0.
REQ-034 In PRESENT with VEC = 2, REQ[6] edge -> VEC stays 2 until ACK; next presentation VEC = 6.
REQ-035 N_EI = 1, edges on bits 3 and 4 -> no VALID, N_EO = 1; N_EI goes 0 -> VEC = 4, then 3.
REQ-036 ACK on the same cycle as a new edge on bit VEC = 1 -> pending[1] stays 1; VEC = 1 is re-presented after RELEASE.
